pulse_acq_framer: RTL and testbench

Parametrised pulse-acquisition framer for the signal-acquisition FPGA. It samples `NUM_CH` asynchronous discrete pulse lines and detects edges per channel in a run-time selectable mode. Each event is timestamped with the shared 32-bit timer and packed into checksummed byte frames. Frames are written into a UART TX FIFO, and a periodic status frame is added on each 10 ms tick. It sits between the board pulse inputs and a `uart` instance, next to `timer32`.

---
 rtl/pulse_acq_pkg.sv | 31 +++
 rtl/pulse_chan.sv | 86 ++++++++
 rtl/pulse_acq_framer.sv | 216 +++++++++++++++++++++
 tb/tb_pulse_acq_framer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_acq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pulse_acq_pkg
// Brief   : Frame constants, edge-mode encodings and framer FSM states.
// Rev     : 1.0
// ============================================================================
package pulse_acq_pkg;

    localparam logic [7:0] HDR_SYNC0   = 8'hEB;
    localparam logic [7:0] HDR_SYNC1   = 8'h90;
    localparam logic [7:0] TYPE_EVENT  = 8'h01;
    localparam logic [7:0] TYPE_STATUS = 8'h02;

    localparam int LEN_EVENT  = 10;
    localparam int LEN_STATUS = 12;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/pulse_chan.sv
`default_nettype none
// ============================================================================
// Module  : pulse_chan
// Brief   : One pulse line: synchroniser, edge detect, timestamp capture, overrun.
// Rev     : 1.0
// ============================================================================
module pulse_chan
    import pulse_acq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ena_i,
    input  logic        pin_i,
    input  logic [1:0]  edge_mode_i,
    input  logic [31:0] count_i,
    input  logic        clr_i,
    output logic        level_o,
    output logic        pending_o,
    output logic        cap_level_o,
    output logic [31:0] ts_o,
    output logic        overrun_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   pending_q, pending_d;
    logic                   cap_level_q, cap_level_d;
    logic [31:0]            ts_q, ts_d;
    logic                   rise, fall, hit;

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise    = level_o & ~prev_q;
    assign fall    = ~level_o & prev_q;

    always_comb begin
        hit = 1'b0;
        case (edge_mode_e'(edge_mode_i))
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        hit = hit & ena_i;
    end

    // A slot being released this cycle may take the new edge; otherwise it is lost.
    assign overrun_o = hit & pending_q & ~clr_i;

    always_comb begin
        pending_d   = pending_q;
        cap_level_d = cap_level_q;
        ts_d        = ts_q;
        if (clr_i) begin
            pending_d = 1'b0;
        end
        if (hit && !overrun_o) begin
            pending_d   = 1'b1;
            cap_level_d = level_o;
            ts_d        = count_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= '0;
            prev_q      <= 1'b0;
            pending_q   <= 1'b0;
            cap_level_q <= 1'b0;
            ts_q        <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q      <= level_o;
            pending_q   <= pending_d;
            cap_level_q <= cap_level_d;
            ts_q        <= ts_d;
        end
    end

    assign pending_o   = pending_q;
    assign cap_level_o = cap_level_q;
    assign ts_o        = ts_q;

endmodule
`default_nettype wire

// File: rtl/pulse_acq_framer.sv
`default_nettype none
// ============================================================================
// Module  : pulse_acq_framer
// Brief   : Timestamped pulse events and periodic status packed into UART frames.
// Rev     : 1.0
// ============================================================================
module pulse_acq_framer
    import pulse_acq_pkg::*;
#(
    parameter int          NUM_CH      = 12,
    parameter int          SYNC_STAGES = 2,
    parameter int          FIFO_DEPTH  = 4096,
    parameter int          USEDW_W     = 12,
    parameter logic [15:0] VERSION     = 16'd0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ena_i,
    input  logic [NUM_CH-1:0]   pulse_in_i,
    input  logic [2*NUM_CH-1:0] edge_mode_i,
    input  logic [31:0]         count_i,
    input  logic                pulse_10ms_i,
    output logic                tx_fifo_wen_o,
    output logic [7:0]          tx_fifo_wdata_o,
    input  logic                tx_fifo_full_i,
    input  logic [USEDW_W-1:0]  tx_fifo_usedw_i,
    output logic [15:0]         drop_cnt_o,
    output logic                busy_o
);

    localparam int          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] USEDW_LIMIT = 32'(FIFO_DEPTH - LEN_STATUS);

    logic [NUM_CH-1:0] level, pending, cap_level, overrun, clr;
    logic [31:0]       ts [NUM_CH];

    fsm_state_e        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic              stat_req_q, stat_req_d;
    logic [15:0]       drop_q, drop_d;
    logic [16:0]       drop_acc;
    logic [CH_W-1:0]   last_q, sel_ch, cand;
    logic              sel_found, fifo_room, last_byte, wen;
    logic [7:0]        byte_val;

    logic              sh_stat_q, sh_level_q;
    logic [CH_W-1:0]   sh_ch_q;
    logic [31:0]       sh_ts_q, sh_levels_q;
    logic [15:0]       sh_drop_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        pulse_chan #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .ena_i       (ena_i),
            .pin_i       (pulse_in_i[g]),
            .edge_mode_i (edge_mode_i[2*g+1:2*g]),
            .count_i     (count_i),
            .clr_i       (clr[g]),
            .level_o     (level[g]),
            .pending_o   (pending[g]),
            .cap_level_o (cap_level[g]),
            .ts_o        (ts[g]),
            .overrun_o   (overrun[g])
        );
        assign clr[g] = (state_q == ST_LOAD) && !stat_req_q && (sel_ch == CH_W'(g));
    end

    // Round-robin: first pending channel strictly after the one served last.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(last_q) + k) % NUM_CH);
            if (!sel_found && pending[cand]) begin
                sel_found = 1'b1;
                sel_ch    = cand;
            end
        end
    end

    always_comb begin
        drop_acc = {1'b0, drop_q} + 17'($countones(overrun));
        drop_d   = drop_acc[16] ? 16'hFFFF : drop_acc[15:0];
    end

    always_comb begin
        stat_req_d = stat_req_q;
        if (pulse_10ms_i && ena_i) begin
            stat_req_d = 1'b1;
        end
        if (state_q == ST_LOAD && stat_req_q) begin
            stat_req_d = 1'b0;
        end
    end

    assign fifo_room = (32'(tx_fifo_usedw_i) <= USEDW_LIMIT);

    always_comb begin
        byte_val  = 8'h00;
        last_byte = sh_stat_q ? (idx_q == 4'(LEN_STATUS - 1)) : (idx_q == 4'(LEN_EVENT - 1));
        if (last_byte) begin
            byte_val = sum_q;
        end else if (sh_stat_q) begin
            case (idx_q)
                4'd0:    byte_val = HDR_SYNC0;
                4'd1:    byte_val = HDR_SYNC1;
                4'd2:    byte_val = TYPE_STATUS;
                4'd3:    byte_val = VERSION[15:8];
                4'd4:    byte_val = VERSION[7:0];
                4'd5:    byte_val = sh_drop_q[15:8];
                4'd6:    byte_val = sh_drop_q[7:0];
                4'd7:    byte_val = sh_levels_q[31:24];
                4'd8:    byte_val = sh_levels_q[23:16];
                4'd9:    byte_val = sh_levels_q[15:8];
                4'd10:   byte_val = sh_levels_q[7:0];
                default: byte_val = 8'h00;
            endcase
        end else begin
            case (idx_q)
                4'd0:    byte_val = HDR_SYNC0;
                4'd1:    byte_val = HDR_SYNC1;
                4'd2:    byte_val = TYPE_EVENT;
                4'd3:    byte_val = 8'(sh_ch_q);
                4'd4:    byte_val = {7'd0, sh_level_q};
                4'd5:    byte_val = sh_ts_q[31:24];
                4'd6:    byte_val = sh_ts_q[23:16];
                4'd7:    byte_val = sh_ts_q[15:8];
                4'd8:    byte_val = sh_ts_q[7:0];
                default: byte_val = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        wen     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ena_i && (stat_req_q || sel_found) && fifo_room) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_d   = '0;
                sum_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_fifo_full_i) begin
                    wen   = 1'b1;
                    idx_d = idx_q + 4'd1;
                    // Sync bytes are excluded from the checksum.
                    if (idx_q >= 4'd2) begin
                        sum_d = sum_q + byte_val;
                    end
                    if (last_byte) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            sum_q      <= '0;
            stat_req_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            stat_req_q <= stat_req_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_stat_q   <= 1'b0;
            sh_ch_q     <= '0;
            sh_level_q  <= 1'b0;
            sh_ts_q     <= '0;
            sh_drop_q   <= '0;
            sh_levels_q <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
        end else if (state_q == ST_LOAD) begin
            sh_stat_q   <= stat_req_q;
            sh_ch_q     <= sel_ch;
            sh_level_q  <= cap_level[sel_ch];
            sh_ts_q     <= ts[sel_ch];
            sh_drop_q   <= drop_q;
            sh_levels_q <= 32'(level);
            if (!stat_req_q) begin
                last_q <= sel_ch;
            end
        end
    end

    assign tx_fifo_wen_o   = wen;
    assign tx_fifo_wdata_o = wen ? byte_val : 8'h00;
    assign drop_cnt_o      = drop_q;
    assign busy_o          = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pulse_acq_framer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pulse_acq_framer
// Brief   : Directed and random frame checks against a queue-based frame model.
// Rev     : 1.0
// ============================================================================
module tb_pulse_acq_framer;

    localparam int          NCH = 12;
    localparam logic [15:0] VER = 16'h0102;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b1;
    logic             ena        = 1'b0;
    logic             pulse_10ms = 1'b0;
    logic             full       = 1'b0;
    logic [NCH-1:0]   pins       = '0;
    logic [2*NCH-1:0] modes      = '0;
    logic [31:0]      count      = '0;
    logic [11:0]      usedw      = '0;
    logic             wen, busy;
    logic [7:0]       wdata;
    logic [15:0]      drop;

    pulse_acq_framer #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (4096),
        .USEDW_W     (12),
        .VERSION     (VER)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ena_i           (ena),
        .pulse_in_i      (pins),
        .edge_mode_i     (modes),
        .count_i         (count),
        .pulse_10ms_i    (pulse_10ms),
        .tx_fifo_wen_o   (wen),
        .tx_fifo_wdata_o (wdata),
        .tx_fifo_full_i  (full),
        .tx_fifo_usedw_i (usedw),
        .drop_cnt_o      (drop),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  body_q[$];
    bit          pend [NCH];
    logic [31:0] pts  [NCH];
    logic        plvl [NCH];
    int          last_srv;
    int          drop_m;
    bit          stat_m;

    always @(negedge clk) begin
        if (wen) got_q.push_back(wdata);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic close_frame();
        logic [7:0] s;
        s = 8'h00;
        exp_q.push_back(8'hEB);
        exp_q.push_back(8'h90);
        foreach (body_q[i]) begin
            exp_q.push_back(body_q[i]);
            s = s + body_q[i];
        end
        exp_q.push_back(s);
        body_q.delete();
    endtask

    task automatic push_evt(input int ch, input logic lvl, input logic [31:0] ts);
        body_q.push_back(8'h01);
        body_q.push_back(8'(ch));
        body_q.push_back(lvl ? 8'h01 : 8'h00);
        for (int b = 3; b >= 0; b--) body_q.push_back(ts[8*b +: 8]);
        close_frame();
    endtask

    task automatic push_stat(input logic [15:0] d, input logic [31:0] lv);
        body_q.push_back(8'h02);
        body_q.push_back(VER[15:8]);
        body_q.push_back(VER[7:0]);
        body_q.push_back(d[15:8]);
        body_q.push_back(d[7:0]);
        for (int b = 3; b >= 0; b--) body_q.push_back(lv[8*b +: 8]);
        close_frame();
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) pend[c] = 0;
        last_srv = NCH - 1;
        drop_m   = 0;
        stat_m   = 0;
    endtask

    // Everything queued is served: status first, then channels in rotation.
    task automatic model_flush();
        if (stat_m) begin
            push_stat(16'(drop_m), 32'(pins));
            stat_m = 0;
        end
        for (int n = 0; n < NCH; n++) begin
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (last_srv + k) % NCH;
                if (pend[c]) begin
                    push_evt(c, plvl[c], pts[c]);
                    pend[c]  = 0;
                    last_srv = c;
                    break;
                end
            end
        end
    endtask

    task automatic apply_pins(input logic [NCH-1:0] np, input logic [31:0] cnt);
        for (int c = 0; c < NCH; c++) begin
            if (np[c] !== pins[c]) begin
                logic [1:0] m;
                bit         rise;
                m    = modes[2*c +: 2];
                rise = np[c];
                if (ena && (m == 2'b11 || (m == 2'b01 && rise) || (m == 2'b10 && !rise))) begin
                    if (pend[c]) begin
                        if (drop_m < 65535) drop_m++;
                    end else begin
                        pend[c] = 1;
                        pts[c]  = cnt;
                        plvl[c] = np[c];
                    end
                end
            end
        end
        count = cnt;
        pins  = np;
        tick(8);
    endtask

    task automatic tick_10ms();
        pulse_10ms = 1'b1;
        if (ena) stat_m = 1;
        tick(1);
        pulse_10ms = 1'b0;
        tick(2);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        pins       = '0;
        modes      = '0;
        usedw      = '0;
        full       = 1'b0;
        pulse_10ms = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        model_reset();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic drain_compare(input string tag);
        model_flush();
        for (int c = 0; c < 3000 && got_q.size() < exp_q.size(); c++) tick(1);
        tick(30);
        check($sformatf("%s nbytes", tag), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s byte%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        #3;
        check("rst wen", wen, 0);
        check("rst wdata", wdata, 0);
        check("rst drop", drop, 0);
        check("rst busy", busy, 0);
        ena = 1'b1;
        do_reset();

        // Single rising edge, with the FIFO-room threshold straddled.
        modes[7:6] = 2'b01;
        usedw      = 12'd4085;
        apply_pins(12'h008, 32'h12345678);
        tick(10);
        check("thresh busy", busy, 0);
        check("thresh nbytes", 64'(got_q.size()), 0);
        usedw = 12'd4084;
        drain_compare("single");

        // Simultaneous edges on ch0, ch5, ch11.
        do_reset();
        modes[1:0]   = 2'b01;
        modes[11:10] = 2'b01;
        modes[23:22] = 2'b01;
        apply_pins(12'h821, $urandom);
        drain_compare("simul");
        check("simul drop", drop, 64'(drop_m));

        // Overrun on ch2 while frames are held back.
        do_reset();
        modes[5:4] = 2'b11;
        usedw      = 12'd4090;
        apply_pins(12'h004, $urandom);
        apply_pins(12'h000, $urandom);
        apply_pins(12'h004, $urandom);
        check("ovr drop held", drop, 64'(drop_m));
        usedw = 12'd0;
        drain_compare("ovr");
        check("ovr drop", drop, 64'(drop_m));

        // Status tick coincident with a pending ch1 falling edge.
        do_reset();
        usedw = 12'd4090;
        apply_pins(12'h007, $urandom);
        modes[3:2] = 2'b10;
        apply_pins(12'h005, $urandom);
        tick_10ms();
        usedw = 12'd0;
        drain_compare("stat");

        // FIFO full for 5 cycles mid-frame.
        do_reset();
        modes[15:14] = 2'b01;
        usedw        = 12'd4090;
        apply_pins(12'h080, $urandom);
        usedw = 12'd0;
        for (int c = 0; c < 50 && got_q.size() < 3; c++) tick(1);
        full = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check($sformatf("stall%0d wen", s), wen, 0);
            check($sformatf("stall%0d busy", s), busy, 1);
            tick(1);
        end
        full = 1'b0;
        drain_compare("stall");

        // Reset asserted at byte 4 of a frame.
        do_reset();
        apply_pins(12'h010, $urandom);
        modes[9:8] = 2'b10;
        usedw      = 12'd4090;
        apply_pins(12'h000, $urandom);
        usedw = 12'd0;
        for (int c = 0; c < 50 && got_q.size() < 4; c++) tick(1);
        rst_n = 1'b0;
        #1;
        check("midrst wen", wen, 0);
        check("midrst wdata", wdata, 0);
        check("midrst drop", drop, 0);
        check("midrst busy", busy, 0);
        tick(3);
        rst_n = 1'b1;
        model_reset();
        got_q.delete();
        tick(40);
        check("postrst nbytes", 64'(got_q.size()), 0);
        check("postrst busy", busy, 0);

        // Disabled: edges and ticks are ignored.
        do_reset();
        modes = '1;
        ena   = 1'b0;
        apply_pins(12'hFFF, $urandom);
        tick_10ms();
        tick(10);
        check("ena0 drop", drop, 0);
        ena = 1'b1;
        drain_compare("ena0");

        // Random batches accumulated behind a nearly-full FIFO.
        do_reset();
        modes = 24'($urandom);
        for (int b = 0; b < 4; b++) begin
            usedw = 12'd4090;
            for (int r = 0; r < 4; r++) apply_pins(pins ^ NCH'($urandom), $urandom);
            if ($urandom_range(0, 1) == 1) tick_10ms();
            check($sformatf("rand%0d drop", b), drop, 64'(drop_m));
            usedw = 12'd0;
            drain_compare($sformatf("rand%0d", b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
